// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared mask indices and entry layout for the x/y/z trace buffer
package trace_pkg;

  localparam int X_BIT        = 0;
  localparam int Y_BIT        = 1;
  localparam int Z_BIT        = 2;
  localparam int MASK_W       = 3;
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_TS_WIDTH = 16;

  // Layout reference at default widths; the top rebuilds the same order for its own parameters.
  typedef struct packed {
    logic [DEF_TS_WIDTH-1:0] ts;
    logic [MASK_W-1:0]       mask;
    logic                    lost;
    logic [DEF_WIDTH-1:0]    x;
    logic [DEF_WIDTH-1:0]    y;
    logic [DEF_WIDTH-1:0]    z;
  } trace_entry_t;

  function automatic int entry_width(input int w, input int ts_w);
    return ts_w + MASK_W + 1 + 3 * w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous first-word-fall-through FIFO, extra pointer bit for full/empty
module trace_fifo #(
  parameter int EW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [EW-1:0]              din_i,
  input  logic                       pop_i,
  output logic [EW-1:0]              dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/xyz_trace_buffer.sv
// rtl/xyz_trace_buffer.sv - change-capture recorder for x/y/z with timestamped FIFO and drop accounting
module xyz_trace_buffer
  import trace_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         y,
  input  logic [WIDTH-1:0]         z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_WIDTH-1:0]      out_ts,
  output logic [2:0]               out_mask,
  output logic                     out_lost,
  output logic [WIDTH-1:0]         out_x,
  output logic [WIDTH-1:0]         out_y,
  output logic [WIDTH-1:0]         out_z,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_count
);

  localparam int EW = entry_width(WIDTH, TS_WIDTH);

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [MASK_W-1:0]   mask;
    logic                lost;
    logic [WIDTH-1:0]    x;
    logic [WIDTH-1:0]    y;
    logic [WIDTH-1:0]    z;
  } entry_t;

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [WIDTH-1:0]    snap_x_q, snap_x_d;
  logic [WIDTH-1:0]    snap_y_q, snap_y_d;
  logic [WIDTH-1:0]    snap_z_q, snap_z_d;
  logic                snap_vld_q, snap_vld_d;
  logic                lost_q, lost_d;
  logic [7:0]          drop_q, drop_d;

  logic [MASK_W-1:0]   mask_c;
  logic                capture, push, pop, drop;
  entry_t              push_entry, head_entry;
  logic [EW-1:0]       fifo_dout;
  logic                fifo_full, fifo_empty;

  always_comb begin
    mask_c = '1;
    if (snap_vld_q) begin
      mask_c[X_BIT] = (x != snap_x_q);
      mask_c[Y_BIT] = (y != snap_y_q);
      mask_c[Z_BIT] = (z != snap_z_q);
    end
    capture = in_valid && (mask_c != '0);
    pop     = out_ready && !fifo_empty;
    drop    = capture && fifo_full && !pop;
    push    = capture && !drop;

    push_entry.ts   = ts_q;
    push_entry.mask = mask_c;
    push_entry.lost = lost_q;
    push_entry.x    = x;
    push_entry.y    = y;
    push_entry.z    = z;

    ts_d       = ts_q + 1'b1;
    snap_x_d   = snap_x_q;
    snap_y_d   = snap_y_q;
    snap_z_d   = snap_z_q;
    snap_vld_d = snap_vld_q;
    lost_d     = lost_q;
    drop_d     = drop_q;

    // Snapshot tracks every capture, even dropped ones, so later masks stay relative to what was seen.
    if (capture) begin
      snap_x_d   = x;
      snap_y_d   = y;
      snap_z_d   = z;
      snap_vld_d = 1'b1;
    end
    if (drop) begin
      lost_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (push) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_z_q   <= '0;
      snap_vld_q <= 1'b0;
      lost_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      snap_z_q   <= snap_z_d;
      snap_vld_q <= snap_vld_d;
      lost_q     <= lost_d;
      drop_q     <= drop_d;
    end
  end

  trace_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // Stale storage must not leak out while the FIFO is empty.
  assign head_entry = fifo_empty ? '0 : entry_t'(fifo_dout);
  assign out_valid  = !fifo_empty;
  assign out_ts     = head_entry.ts;
  assign out_mask   = head_entry.mask;
  assign out_lost   = head_entry.lost;
  assign out_x      = head_entry.x;
  assign out_y      = head_entry.y;
  assign out_z      = head_entry.z;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_xyz_trace_buffer.sv
// tb/tb_xyz_trace_buffer.sv - directed self-checking bench for xyz_trace_buffer
module tb_xyz_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] x, y, z;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ts;
  logic [2:0]  out_mask;
  logic        out_lost;
  logic [31:0] out_x, out_y, out_z;
  logic [3:0]  level;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  xyz_trace_buffer #(.WIDTH(32), .DEPTH(8), .TS_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .x          (x),
    .y          (y),
    .z          (z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ts     (out_ts),
    .out_mask   (out_mask),
    .out_lost   (out_lost),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_z      (out_z),
    .level      (level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; z = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    n_checks++; if ({out_ts, out_mask, out_lost, out_x} !== '0) begin n_fail++; $display("FAIL reset_out_zero got ts=%0d mask=%b x=%0d", out_ts, out_mask, out_x); end
    in_valid = 1'b1; x = 32'd5;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %0d want 1", out_valid); end
    n_checks++; if (out_ts !== 16'd0) begin n_fail++; $display("FAIL first_ts got %0d want 0", out_ts); end
    n_checks++; if (out_mask !== 3'b111) begin n_fail++; $display("FAIL first_mask got %b want 111", out_mask); end
    n_checks++; if (out_x !== 32'd5 || out_lost !== 1'b0) begin n_fail++; $display("FAIL first_x got x=%0d lost=%0d want 5/0", out_x, out_lost); end
    tick();
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL hold_level got %0d want 1", level); end
    out_ready = 1'b1;
    tick();
    repeat (3) tick();
    n_checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL hold_no_more got valid=%0d level=%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_stream();
    logic [2:0] exp_mask;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      x = 32'(c + 100);
      y = (c >= 10) ? 32'd6 : 32'd0;
      z = (c >= 20) ? 32'd7 : 32'd0;
      tick();
      exp_mask = (c == 0) ? 3'b111 : (c == 10) ? 3'b011 : (c == 20) ? 3'b101 : 3'b001;
      n_checks++; if (out_valid !== 1'b1 || out_ts !== 16'(c) || level !== 4'd1) begin n_fail++; $display("FAIL stream_ts c=%0d got valid=%0d ts=%0d level=%0d", c, out_valid, out_ts, level); end
      n_checks++; if (out_mask !== exp_mask || out_x !== 32'(c + 100)) begin n_fail++; $display("FAIL stream_mask c=%0d got mask=%b x=%0d want %b/%0d", c, out_mask, out_x, exp_mask, c + 100); end
      if (c == 10 || c == 20) begin
        n_checks++; if (out_y !== y || out_z !== z) begin n_fail++; $display("FAIL stream_yz c=%0d got y=%0d z=%0d want %0d/%0d", c, out_y, out_z, y, z); end
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got level=%0d valid=%0d want 0/0", level, out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    in_valid = 1'b1;
    for (int c = 0; c < 11; c++) begin
      x = 32'(c + 1);
      tick();
    end
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", level); end
    n_checks++; if (drop_count !== 8'd3) begin n_fail++; $display("FAIL ovf_drop got %0d want 3", drop_count); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (out_ts !== 16'(k) || out_lost !== 1'b0) begin n_fail++; $display("FAIL ovf_drain k=%0d got ts=%0d lost=%0d want %0d/0", k, out_ts, out_lost, k); end
      tick();
    end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL ovf_empty got %0d want 0", level); end
    in_valid = 1'b1; x = 32'd1000;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_lost !== 1'b1 || out_mask !== 3'b001) begin n_fail++; $display("FAIL ovf_lost1 got valid=%0d lost=%0d mask=%b want 1/1/001", out_valid, out_lost, out_mask); end
    x = 32'd1001;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_lost !== 1'b0 || out_x !== 32'd1001) begin n_fail++; $display("FAIL ovf_lost0 got valid=%0d lost=%0d x=%0d want 1/0/1001", out_valid, out_lost, out_x); end
    n_checks++; if (drop_count !== 8'd3) begin n_fail++; $display("FAIL ovf_drop_hold got %0d want 3", drop_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      x = 32'(c + 50);
      tick();
    end
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL b2b_fill got %0d want 8", level); end
    out_ready = 1'b1;
    for (int c = 8; c < 12; c++) begin
      x = 32'(c + 50);
      n_checks++; if (out_ts !== 16'(c - 8)) begin n_fail++; $display("FAIL b2b_order c=%0d got ts=%0d want %0d", c, out_ts, c - 8); end
      tick();
      n_checks++; if (level !== 4'd8 || drop_count !== 8'd0) begin n_fail++; $display("FAIL b2b_level c=%0d got level=%0d drop=%0d want 8/0", c, level, drop_count); end
    end
  endtask

  task automatic test_valid_toggle();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; x = 32'd1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_ts !== 16'd0) begin n_fail++; $display("FAIL tog_first got valid=%0d ts=%0d want 1/0", out_valid, out_ts); end
    in_valid = 1'b0; x = 32'd2;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tog_invalid got %0d want 0", out_valid); end
    in_valid = 1'b1; x = 32'd1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tog_same_as_last got %0d want 0", out_valid); end
    in_valid = 1'b0; x = 32'd9;
    tick();
    in_valid = 1'b1; x = 32'd3;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_ts !== 16'd4 || out_x !== 32'd3 || out_mask !== 3'b001) begin n_fail++; $display("FAIL tog_change got valid=%0d ts=%0d x=%0d mask=%b want 1/4/3/001", out_valid, out_ts, out_x, out_mask); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    repeat (65533) tick();
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      x = 32'(c + 200);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (out_ts !== 16'(65533 + k)) begin n_fail++; $display("FAIL wrap_pre k=%0d got ts=%0d want %0d", k, out_ts, 65533 + k); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (out_ts !== 16'd0 || level !== 4'd5) begin n_fail++; $display("FAIL wrap_zero got ts=%0d level=%0d want 0/5", out_ts, level); end
    rst = 1'b1; in_valid = 1'b1; x = 32'd77;
    tick();
    rst = 1'b0;
    n_checks++; if (level !== 4'd0 || drop_count !== 8'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_reset got level=%0d drop=%0d valid=%0d want 0/0/0", level, drop_count, out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_ts !== 16'd0 || out_mask !== 3'b111 || out_x !== 32'd77) begin n_fail++; $display("FAIL wrap_first got valid=%0d ts=%0d mask=%b x=%0d want 1/0/111/77", out_valid, out_ts, out_mask, out_x); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_back_to_back();
    test_valid_toggle();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xyz_trace_buffer.md
# xyz_trace_buffer

Change-capture recorder that sits directly downstream of the x/y/z variable stage. Every cycle it samples the three 32-bit values. Whenever any of them differs from the last recorded snapshot, it stores a timestamped entry in a small FIFO. A consumer drains the FIFO over a valid/ready port, so the x/y/z evolution can be inspected without per-cycle `$display`/`$write`.

## Interface
Parameters:
- `WIDTH`, 32, bit width of x, y, z
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `TS_WIDTH`, 16, timestamp counter width

Ports:
- `clk`  in  1  rising-edge clock; one clock only
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  x/y/z are meaningful this cycle
- `x`, `y`, `z`  in  WIDTH each  monitored values
- `out_valid`  out  1  FIFO head entry available
- `out_ready`  in  1  consumer accepts head this cycle
- `out_ts`  out  TS_WIDTH  cycle stamp of the head entry
- `out_mask`  out  3  changed fields {z,y,x}, bit0 = x
- `out_lost`  out  1  ≥1 entry dropped immediately before this one
- `out_x`, `out_y`, `out_z`  out  WIDTH each  snapshot values
- `level`  out  $clog2(DEPTH)+1  current occupancy
- `drop_count`  out  8  total dropped entries, saturating

## Operation
- Timestamp counter `ts`:
  - 0 in the first cycle after reset; +1 every cycle.
  - Wraps modulo 2^TS_WIDTH, with no flag.
- Snapshot register (last x/y/z recorded) plus `snap_vld`; `snap_vld`=0 after reset.
- Capture condition, evaluated per cycle with `in_valid`=1:
  - `snap_vld`=0: capture; mask=3'b111.
  - Otherwise mask[i] = field i != snapshot field i; capture if mask≠0.
  - `in_valid`=0: no compare, no capture; snapshot and counter unaffected except `ts` increments.
- On capture:
  - Snapshot updates to current x/y/z and `snap_vld`←1, whether or not the push succeeds.
  - Entry {ts, mask, lost_pending, x, y, z} is pushed.
- Full FIFO with no simultaneous pop:
  - Push is dropped.
  - `drop_count` increments, saturating at 255.
  - `lost_pending` is set.
- `lost_pending`:
  - Copied into the next successfully pushed entry, then cleared in the same cycle.
- FIFO is first-word-fall-through:
  - `out_*` reflect the head whenever `out_valid`=1.
  - Pop occurs when `out_valid && out_ready`.
- Push and pop in the same cycle:
  - Both succeed, including when the FIFO is full, since the pop frees the slot. `level` is unchanged.
- Empty FIFO with push and `out_ready`=1: no bypass; the entry appears next cycle.
- Reset values: `out_valid`=0, `level`=0, `drop_count`=0, `lost_pending`=0, `snap_vld`=0, `ts`=0.
  - `out_ts`/`out_mask`/`out_lost`/`out_x`/`out_y`/`out_z`=0 while empty.
- Reset mid-operation discards all entries and the snapshot. The first valid sample after reset is recorded again with mask 3'b111.

## Timing
- Sampled at rising `clk`. An entry captured at edge N is visible on `out_*` after edge N (latency 1) if the FIFO was empty.
- `out_*` and `level` are registered or driven directly from FIFO state. There is no combinational path from x/y/z/`in_valid` to outputs.
- `out_ready` may combinationally affect only the pop decision, not `out_valid` in the same cycle.
- Sustained rate: one capture and one pop per cycle.
- `rst` has priority over all other inputs in the cycle it is high.

## Structure
- Shared package/header `trace_pkg`:
  - Mask bit indices X_BIT=0, Y_BIT=1, Z_BIT=2.
  - Entry field layout/width constants and the packed entry typedef.
- Sub-module `trace_fifo`: synchronous FWFT FIFO.
  - Parameters: entry width, DEPTH.
  - Ports: push/pop, full/empty, level.
  - Uses an extra pointer bit for full/empty.
- Top contains the `ts` counter, snapshot/compare logic, drop accounting and `lost_pending`.

## Test plan
- Reset, then `in_valid`=1 with x=5, y=0, z=0 held:
  - Exactly one entry: ts=0, mask=111, x=5.
  - `out_valid` stays 0 after it is popped.
- Per-cycle x increments, plus y=6 at cycle 10 and z=7 at cycle 20, `out_ready`=1:
  - One entry per cycle.
  - Entries at ts 10 and 20 show mask 011 and 101 with correct values.
- `out_ready`=0 with 11 distinct changes at DEPTH=8:
  - `level`=8, `drop_count`=3.
  - After draining and one further change, that entry has `out_lost`=1 and the next has `out_lost`=0.
- Full FIFO with simultaneous change and `out_ready`=1 for 4 cycles:
  - No drops; `level` stays 8.
  - Popped ts values are consecutive and in order.
- `in_valid` toggling 1/0 with changing inputs:
  - Captures only on valid cycles.
  - The compare is against the last valid sample, not the intervening values.
- Assert `rst` with 5 entries queued and `ts` near 2^16−1, with wrap checked first:
  - Before reset: an entry at ts=65535 is followed by one at ts=0.
  - Next cycle after reset: `level`=0, `drop_count`=0.
  - First valid sample is recorded with mask 111 and ts=0.
